// File: rtl/add_round_key.sv
// AES AddRoundKey stage: XORs the MixColumns state with the round key for
// the current round. Round keys live in a small register file loaded from
// key expansion or firmware; an internal round counter selects the key and
// flags the final round for the round controller.

// Round-key register file: NR+1 slots, one write port, one combinational
// read port. Writes to slots beyond NR are dropped and reported.
module ark_key_file #(
  parameter int DATA_W = 128,
  parameter int NR     = 10,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

  logic [DATA_W-1:0] key_mem [0:NR];
  logic              wr_addr_ok;

  assign wr_addr_ok = (wr_addr <= LAST_IDX);

  // Read is combinational so a same-cycle write is only seen from the next cycle.
  assign rd_data = key_mem[rd_addr];

  // Slot storage: cleared on reset, updated only for in-range addresses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= NR; i++) begin
        key_mem[i] <= '0;
      end
    end else if (wr_en && wr_addr_ok) begin
      key_mem[wr_addr] <= wr_data;
    end
  end

  // Rejected-write flag, high for exactly the cycle after the bad write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_addr_ok;
    end
  end

endmodule

module add_round_key #(
  parameter int DATA_W = 128,
  parameter int NR     = 10,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_addr,
  input  logic [DATA_W-1:0] key_wr_data,
  output logic              key_wr_err,
  input  logic              start,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [IDX_W-1:0]  round_out,
  output logic              last_round
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

  logic [IDX_W-1:0]  round_cnt;
  logic [IDX_W-1:0]  beat_idx;
  logic [DATA_W-1:0] round_key;
  logic              beat_is_last;

  ark_key_file #(
    .DATA_W (DATA_W),
    .NR     (NR),
    .IDX_W  (IDX_W)
  ) u_key_file (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (key_wr_en),
    .wr_addr (key_wr_addr),
    .wr_data (key_wr_data),
    .wr_err  (key_wr_err),
    .rd_addr (beat_idx),
    .rd_data (round_key)
  );

  // A start in the same cycle as a beat overrides the counter so the first
  // beat of a block always uses key 0.
  assign beat_idx     = start ? '0 : round_cnt;
  assign beat_is_last = (beat_idx == LAST_IDX);

  // Round counter: advances per accepted beat, wraps after the final round.
  always_ff @(posedge clk) begin
    if (reset) begin
      round_cnt <= '0;
    end else if (valid_in) begin
      round_cnt <= beat_is_last ? '0 : beat_idx + 1'b1;
    end else if (start) begin
      round_cnt <= '0;
    end
  end

  // Output strobes: valid and last-round flag follow the input beat by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out  <= 1'b0;
      last_round <= 1'b0;
    end else begin
      valid_out  <= valid_in;
      last_round <= valid_in && beat_is_last;
    end
  end

  // Output data and round index: captured on a beat, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      round_out <= '0;
    end else if (valid_in) begin
      data_out  <= data_in ^ round_key;
      round_out <= beat_idx;
    end
  end

endmodule

// File: tb/tb_add_round_key.sv
// Self-checking bench for add_round_key: directed AES vectors and boundary
// cases followed by randomized traffic, all checked against a round-level
// reference model kept here.
module tb_add_round_key;

  localparam int DATA_W = 128;
  localparam int NR     = 10;
  localparam int IDX_W  = 4;

  logic              clk;
  logic              reset;
  logic              key_wr_en;
  logic [IDX_W-1:0]  key_wr_addr;
  logic [DATA_W-1:0] key_wr_data;
  logic              key_wr_err;
  logic              start;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic [IDX_W-1:0]  round_out;
  logic              last_round;

  add_round_key #(
    .DATA_W (DATA_W),
    .NR     (NR),
    .IDX_W  (IDX_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_wr_en   (key_wr_en),
    .key_wr_addr (key_wr_addr),
    .key_wr_data (key_wr_data),
    .key_wr_err  (key_wr_err),
    .start       (start),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .round_out   (round_out),
    .last_round  (last_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [DATA_W-1:0] m_keys [0:NR];
  int                m_round;
  logic              e_valid;
  logic              e_last;
  logic              e_err;
  logic [DATA_W-1:0] e_data;
  int                e_round;

  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int idx;
    if (reset) begin
      for (int i = 0; i <= NR; i++) m_keys[i] = '0;
      m_round = 0;
      e_valid = 0; e_last = 0; e_err = 0; e_data = '0; e_round = 0;
      return;
    end
    idx = start ? 0 : m_round;
    if (valid_in) begin
      e_data  = data_in ^ m_keys[idx];
      e_round = idx;
      e_valid = 1;
      e_last  = (idx == NR);
      m_round = (idx + 1) % (NR + 1);
    end else begin
      e_valid = 0;
      e_last  = 0;
      if (start) m_round = 0;
    end
    e_err = key_wr_en && (int'(key_wr_addr) > NR);
    if (key_wr_en && int'(key_wr_addr) <= NR) m_keys[key_wr_addr] = key_wr_data;
  endtask

  // Apply one cycle of stimulus, clock it, and compare every output.
  task automatic cycle(input logic rst, input logic we, input int addr,
                       input logic [DATA_W-1:0] wdata, input logic st,
                       input logic v, input logic [DATA_W-1:0] din);
    reset       = rst;
    key_wr_en   = we;
    key_wr_addr = IDX_W'(addr);
    key_wr_data = wdata;
    start       = st;
    valid_in    = v;
    data_in     = din;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("valid_out",  DATA_W'(valid_out),  DATA_W'(e_valid));
    check("last_round", DATA_W'(last_round), DATA_W'(e_last));
    check("key_wr_err", DATA_W'(key_wr_err), DATA_W'(e_err));
    check("data_out",   data_out,            e_data);
    check("round_out",  DATA_W'(round_out),  DATA_W'(e_round));
  endtask

  task automatic idle();
    cycle(0, 0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    reset = 1; key_wr_en = 0; key_wr_addr = '0; key_wr_data = '0;
    start = 0; valid_in = 0; data_in = '0;
    m_round = 0;
    for (int i = 0; i <= NR; i++) m_keys[i] = '0;
    @(negedge clk);

    // Reset state.
    cycle(1, 0, 0, '0, 0, 0, '0);
    check("rst_valid", DATA_W'(valid_out), '0);
    check("rst_data",  data_out, '0);

    // FIPS-197 round 0 and round 1 vectors.
    cycle(0, 1, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 0, '0);
    cycle(0, 1, 1, 128'ha0fafe1788542cb123a339392a6c7605, 1, 1,
          128'h3243f6a8885a308d313198a2e0370734);
    check("aes_r0", data_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("aes_r0_round", DATA_W'(round_out), '0);
    cycle(0, 0, 0, '0, 0, 1, 128'h046681e5e0cb199a48f8d37a2806264c);
    check("aes_r1", data_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
    check("aes_r1_round", DATA_W'(round_out), DATA_W'(1));
    idle();

    // Eleven beats plus a wrap with zero keys.
    cycle(1, 0, 0, '0, 0, 0, '0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, '0, (i == 0), 1, DATA_W'(i));
      check("seq_round", DATA_W'(round_out), DATA_W'(i % (NR + 1)));
      check("seq_last", DATA_W'(last_round), DATA_W'(i == NR));
      check("seq_data", data_out, DATA_W'(i));
    end
    idle();

    // Out-of-range key write is rejected and leaves slot 0 intact.
    cycle(0, 1, 11, ONES, 0, 0, '0);
    check("err_pulse", DATA_W'(key_wr_err), DATA_W'(1));
    idle();
    check("err_clear", DATA_W'(key_wr_err), '0);
    cycle(0, 0, 0, '0, 1, 1, '0);
    check("err_slot0", data_out, '0);

    // Same-cycle write/read uses the old key.
    cycle(0, 1, 0, ONES, 1, 1, '0);
    check("wr_rd_old", data_out, '0);
    cycle(0, 0, 0, '0, 1, 1, '0);
    check("wr_rd_new", data_out, ONES);

    // Reset between beat 3 and beat 4.
    cycle(0, 1, 2, rand_word(), 1, 1, rand_word());
    cycle(0, 0, 0, '0, 0, 1, rand_word());
    cycle(0, 0, 0, '0, 0, 1, rand_word());
    cycle(1, 0, 0, '0, 0, 1, rand_word());
    check("rst_mid_valid", DATA_W'(valid_out), '0);
    cycle(0, 0, 0, '0, 0, 1, 128'hdeadbeef_01234567_89abcdef_cafef00d);
    check("rst_mid_data", data_out, 128'hdeadbeef_01234567_89abcdef_cafef00d);
    check("rst_mid_round", DATA_W'(round_out), '0);

    // Randomized traffic: load all keys, then mixed beats/writes/starts.
    for (int i = 0; i <= NR; i++) cycle(0, 1, i, rand_word(), 0, 0, '0);
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 25), int'($urandom_range(0, 15)),
            rand_word(),
            ($urandom_range(0, 99) < 8),
            ($urandom_range(0, 99) < 75), rand_word());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_round_key.md
Name: add_round_key

Overview:
- AES AddRoundKey stage sitting directly downstream of the MixColumns stage; consumes its 128-bit state output and XORs it with the round key for the current round.
- Holds all NR+1 round keys in an internal register file, loaded through a write port from key expansion or firmware.
- Tracks the round number with an internal counter and flags the final round so the round controller can route the result out.

Parameters:
- DATA_W, 128, state and round-key width in bits.
- NR, 10, number of AES rounds; the key file holds NR+1 keys, indices 0..NR.
- IDX_W, 4, width of key index and round counter; must satisfy 2^IDX_W > NR.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- key_wr_en  input  1  round-key write strobe
- key_wr_addr  input  IDX_W  round-key slot to write
- key_wr_data  input  DATA_W  round-key value
- key_wr_err  output  1  one-cycle pulse: write to slot > NR was rejected
- start  input  1  begin new block; forces round index to 0
- valid_in  input  1  data_in valid this cycle
- data_in  input  DATA_W  state from upstream stage
- valid_out  output  1  data_out valid this cycle
- data_out  output  DATA_W  data_in XOR round key
- round_out  output  IDX_W  round index used for the current data_out
- last_round  output  1  high with valid_out when round_out == NR

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- On reset:
  - valid_out, last_round and key_wr_err are 0.
  - data_out and round_out are 0.
  - The round counter is 0.
  - All key slots are cleared to 0.
- Key write (key_wr_en=1):
  - If key_wr_addr <= NR, slot key_wr_addr is updated at the clock edge.
  - If key_wr_addr > NR, no slot changes and key_wr_err pulses high the next cycle for exactly one cycle.
- Round index used for a beat:
  - 0 if start=1 in the same cycle as valid_in.
  - Otherwise the current counter value.
- Accepted beat (valid_in=1), at the next edge:
  - data_out <= data_in ^ key[idx] (bitwise, full DATA_W).
  - round_out <= idx; valid_out <= 1; last_round <= (idx == NR).
- Latency: exactly 1 cycle from valid_in to valid_out. No back-pressure; a beat is accepted every cycle valid_in=1.
- Counter update on an accepted beat: counter <= idx+1, or 0 if idx == NR (wrap).
- start without valid_in: counter <= 0; no output is produced.
- No valid_in:
  - valid_out <= 0 and last_round <= 0.
  - data_out and round_out hold their previous values.
- Same-cycle key write and read of the same slot: the beat uses the OLD key value; the new key applies from the next cycle.
- Keys may be rewritten while beats are flowing; only the slot being written is affected.
- Reset asserted mid-block: any output in flight is discarded (valid_out=0 next cycle), the counter returns to 0 and the keys are cleared.
- Byte order is irrelevant to the XOR. Byte 0 of the state is data_in[DATA_W-1:DATA_W-8], matching the upstream stage.

Test Plan:
- Load slot 0 = 2b7e151628aed2a6abf7158809cf4f3c; start+valid_in with data_in = 3243f6a8885a308d313198a2e0370734 -> next cycle valid_out=1, data_out = 193de3bea0f4e22b9ac68d2ae9f84808, round_out=0, last_round=0.
- Load slot 1 = a0fafe1788542cb123a339392a6c7605; second beat data_in = 046681e5e0cb199a48f8d37a2806264c -> data_out = a49c7ff2689f352b6b5bea43026a5049, round_out=1.
- Eleven consecutive beats after start, all keys 0, data_in = beat number -> round_out 0..10, last_round=1 only on the 11th output; 12th beat gives round_out=0 (wrap).
- Write to addr 11 with key_wr_data = all ones -> key_wr_err pulses for one cycle; a subsequent round-0 beat with data_in=0 returns slot 0 unchanged.
- Same cycle: write slot 0 = ff..ff and valid_in+start with data_in=0, previous slot 0 = 0 -> data_out = 0; repeat next cycle -> data_out = ff..ff.
- Assert reset for one cycle between beat 3 and beat 4 -> valid_out=0 the cycle after reset; the next beat without start uses round 0 and key 0, so data_out = data_in.
